// File: rtl/reg_wb_arbiter.sv
// Write-back arbiter: ALU and load unit share one registered register-file write port; a busy-bit scoreboard tracks reserved destinations.
// Define WB_RR_ARB_EN for round-robin contention; the default build gives the load unit fixed priority.
module reg_wb_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic        alu_valid,
    input  logic [4:0]  alu_num,
    input  logic [31:0] alu_data,
    output logic        alu_ready,
    input  logic        lsu_valid,
    input  logic [4:0]  lsu_num,
    input  logic [31:0] lsu_data,
    output logic        lsu_ready,
    output logic        wr_en,
    output logic [4:0]  wr_num,
    output logic [31:0] wr_data,
    input  logic        mark_valid,
    input  logic [4:0]  mark_num,
    input  logic [4:0]  q_num1,
    output logic        q_busy1,
    input  logic [4:0]  q_num2,
    output logic        q_busy2,
    output logic [31:0] busy_vec
);

    logic        alu_fire;
    logic        lsu_fire;
    logic [4:0]  cap_num;
    logic [31:0] cap_data;

    logic        wr_en_q,   wr_en_d;
    logic [4:0]  wr_num_q,  wr_num_d;
    logic [31:0] wr_data_q, wr_data_d;
    logic [31:0] busy_q,    busy_d;

`ifdef WB_RR_ARB_EN
    // last_grant_q: 0 = ALU was granted last, 1 = LSU; reset value 1 lets the ALU win first
    logic        last_grant_q, last_grant_d;

    always_comb begin
        alu_ready = !rst && alu_valid && (!lsu_valid || last_grant_q);
        lsu_ready = !rst && lsu_valid && (!alu_valid || !last_grant_q);
    end
`else
    always_comb begin
        alu_ready = !rst && alu_valid && !lsu_valid;
        lsu_ready = !rst && lsu_valid;
    end
`endif

    always_comb begin
        alu_fire = alu_valid && alu_ready;
        lsu_fire = lsu_valid && lsu_ready;
        cap_num  = lsu_fire ? lsu_num  : alu_num;
        cap_data = lsu_fire ? lsu_data : alu_data;
    end

    // Writes to x0 are accepted but the port stays parked on zero
    always_comb begin
        wr_en_d   = 1'b0;
        wr_num_d  = 5'd0;
        wr_data_d = 32'd0;
        busy_d    = busy_q;
        if ((alu_fire || lsu_fire) && (cap_num != 5'd0)) begin
            wr_en_d         = 1'b1;
            wr_num_d        = cap_num;
            wr_data_d       = cap_data;
            busy_d[cap_num] = 1'b0;
        end
        // Applied after the clear so a same-cycle reservation survives
        if (mark_valid && (mark_num != 5'd0)) begin
            busy_d[mark_num] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

`ifdef WB_RR_ARB_EN
    always_comb begin
        last_grant_d = last_grant_q;
        if (alu_fire || lsu_fire) begin
            last_grant_d = lsu_fire;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_q <= 1'b1;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_en_q   <= 1'b0;
            wr_num_q  <= 5'd0;
            wr_data_q <= 32'd0;
            busy_q    <= 32'd0;
        end else begin
            wr_en_q   <= wr_en_d;
            wr_num_q  <= wr_num_d;
            wr_data_q <= wr_data_d;
            busy_q    <= busy_d;
        end
    end

    assign wr_en    = wr_en_q;
    assign wr_num   = wr_num_q;
    assign wr_data  = wr_data_q;
    assign busy_vec = busy_q;
    assign q_busy1  = busy_q[q_num1];
    assign q_busy2  = busy_q[q_num2];

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter: directed vector table, randomized traffic against a rule-level model, and a mid-operation reset sequence.
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid, lsu_valid, mark_valid;
    logic [4:0]  alu_num, lsu_num, mark_num, q_num1, q_num2;
    logic [31:0] alu_data, lsu_data;
    logic        alu_ready, lsu_ready, wr_en, q_busy1, q_busy2;
    logic [4:0]  wr_num;
    logic [31:0] wr_data, busy_vec;

    reg_wb_arbiter dut (
        .clk(clk), .rst(rst),
        .alu_valid(alu_valid), .alu_num(alu_num), .alu_data(alu_data), .alu_ready(alu_ready),
        .lsu_valid(lsu_valid), .lsu_num(lsu_num), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
        .wr_en(wr_en), .wr_num(wr_num), .wr_data(wr_data),
        .mark_valid(mark_valid), .mark_num(mark_num),
        .q_num1(q_num1), .q_busy1(q_busy1), .q_num2(q_num2), .q_busy2(q_busy2),
        .busy_vec(busy_vec)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model: which register file write is pending, which bits are reserved, who won last
    bit [31:0] m_busy;
    bit        m_we;
    bit [4:0]  m_wn;
    bit [31:0] m_wd;
`ifdef WB_RR_ARB_EN
    bit        m_last;
`endif

    typedef struct {
        logic        av; logic [4:0] an; logic [31:0] ad;
        logic        lv; logic [4:0] ln; logic [31:0] ld;
        logic        mv; logic [4:0] mn;
        logic [4:0]  q1; logic [4:0] q2;
        logic        e_ar; logic e_lr; logic e_qb1; logic e_qb2;
        logic        e_we; logic [4:0] e_wn; logic [31:0] e_wd; logic [31:0] e_busy;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic av, input logic [4:0] an, input logic [31:0] ad,
                                input logic lv, input logic [4:0] ln, input logic [31:0] ld,
                                input logic mv, input logic [4:0] mn,
                                input logic [4:0] q1, input logic [4:0] q2,
                                input logic e_ar, input logic e_lr, input logic e_qb1, input logic e_qb2,
                                input logic e_we, input logic [4:0] e_wn, input logic [31:0] e_wd,
                                input logic [31:0] e_busy);
        vec_t v;
        v.av = av; v.an = an; v.ad = ad; v.lv = lv; v.ln = ln; v.ld = ld;
        v.mv = mv; v.mn = mn; v.q1 = q1; v.q2 = q2;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_qb1 = e_qb1; v.e_qb2 = e_qb2;
        v.e_we = e_we; v.e_wn = e_wn; v.e_wd = e_wd; v.e_busy = e_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = '0; m_we = 0; m_wn = '0; m_wd = '0;
`ifdef WB_RR_ARB_EN
        m_last = 1'b1;
`endif
    endtask

    // Called at a falling edge right after inputs are driven; checks combinational outputs
    task automatic pre(output logic ga, output logic gl);
        #1;
        ga = 1'b0;
        gl = 1'b0;
        if (!rst) begin
            if (alu_valid && lsu_valid) begin
`ifdef WB_RR_ARB_EN
                if (m_last) ga = 1'b1; else gl = 1'b1;
`else
                gl = 1'b1;
`endif
            end else begin
                ga = alu_valid;
                gl = lsu_valid;
            end
        end
        chk("alu_ready", {31'd0, alu_ready}, {31'd0, ga});
        chk("lsu_ready", {31'd0, lsu_ready}, {31'd0, gl});
        chk("q_busy1", {31'd0, q_busy1}, {31'd0, (q_num1 != 0) && m_busy[q_num1]});
        chk("q_busy2", {31'd0, q_busy2}, {31'd0, (q_num2 != 0) && m_busy[q_num2]});
    endtask

    // Crosses one rising edge, advances the model, checks registered outputs, returns at the next falling edge
    task automatic post(input logic ga, input logic gl);
        logic        f  = ga || gl;
        logic [4:0]  n  = ga ? alu_num : lsu_num;
        logic [31:0] d  = ga ? alu_data : lsu_data;
        logic        mv = mark_valid;
        logic [4:0]  mn = mark_num;
        @(posedge clk);
        #1;
        if (f && n != 0) begin
            m_we = 1; m_wn = n; m_wd = d; m_busy[n] = 1'b0;
        end else begin
            m_we = 0; m_wn = 0; m_wd = 0;
        end
        if (mv && mn != 0) m_busy[mn] = 1'b1;
`ifdef WB_RR_ARB_EN
        if (f) m_last = gl;
`endif
        chk("wr_en", {31'd0, wr_en}, {31'd0, m_we});
        chk("wr_num", {27'd0, wr_num}, {27'd0, m_wn});
        chk("wr_data", wr_data, m_wd);
        chk("busy_vec", busy_vec, m_busy);
        $display("cyc alu(%0b,%0d,%08h) lsu(%0b,%0d,%08h) mark(%0b,%0d) -> wr(%0b,%0d,%08h) busy=%08h",
                 ga, alu_num, alu_data, gl, lsu_num, lsu_data, mv, mn, wr_en, wr_num, wr_data, busy_vec);
        @(negedge clk);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic ga, gl, a_fired, l_fired;

        // Reset with every requester active: nothing may be granted or recorded
        rst = 1'b1;
        alu_valid = 1; alu_num = 5'd3; alu_data = 32'h1111_1111;
        lsu_valid = 1; lsu_num = 5'd4; lsu_data = 32'h2222_2222;
        mark_valid = 1; mark_num = 5'd6; q_num1 = 5'd6; q_num2 = 5'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst alu_ready", {31'd0, alu_ready}, 32'd0);
        chk("rst lsu_ready", {31'd0, lsu_ready}, 32'd0);
        chk("rst wr_en", {31'd0, wr_en}, 32'd0);
        chk("rst wr_num", {27'd0, wr_num}, 32'd0);
        chk("rst wr_data", wr_data, 32'd0);
        chk("rst busy_vec", busy_vec, 32'd0);
        rst = 1'b0;
        alu_valid = 0; lsu_valid = 0; mark_valid = 0;

        // Directed table; expectations are hand-derived constants
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 5, 32'hDEADBEEF, 0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 32'h33, 0, 0, 0, 0, 0, 1, 0, 0, 1, 3, 32'h33, 0));
`ifdef WB_RR_ARB_EN
        tbl.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'hA1, 0));
        tbl.push_back(mk(1, 4, 32'hA4, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 32'hB2, 0));
        tbl.push_back(mk(1, 4, 32'hA4, 1, 6, 32'hB6, 0, 0, 0, 0, 1, 0, 0, 0, 1, 4, 32'hA4, 0));
        tbl.push_back(mk(1, 8, 32'hA8, 1, 6, 32'hB6, 0, 0, 0, 0, 0, 1, 0, 0, 1, 6, 32'hB6, 0));
        tbl.push_back(mk(1, 8, 32'hA8, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 8, 32'hA8, 0));
`else
        tbl.push_back(mk(1, 1, 32'hA1, 1, 2, 32'hB2, 0, 0, 0, 0, 0, 1, 0, 0, 1, 2, 32'hB2, 0));
        tbl.push_back(mk(1, 1, 32'hA1, 1, 6, 32'hB6, 0, 0, 0, 0, 0, 1, 0, 0, 1, 6, 32'hB6, 0));
        tbl.push_back(mk(1, 1, 32'hA1, 1, 9, 32'hB9, 0, 0, 0, 0, 0, 1, 0, 0, 1, 9, 32'hB9, 0));
        tbl.push_back(mk(1, 1, 32'hA1, 1, 10, 32'hBA, 0, 0, 0, 0, 0, 1, 0, 0, 1, 10, 32'hBA, 0));
        tbl.push_back(mk(1, 1, 32'hA1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 32'hA1, 0));
`endif
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0, 1, 7, 32'h77, 0, 0, 7, 0, 0, 1, 1, 0, 1, 7, 32'h77, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 7, 0, 7, 0, 0, 0, 0, 0, 0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0, 1, 7, 32'h7777, 1, 7, 7, 0, 0, 1, 1, 0, 1, 7, 32'h7777, 32'h80));
        tbl.push_back(mk(1, 0, 32'h1234, 0, 0, 0, 0, 0, 7, 0, 1, 0, 1, 0, 0, 0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 7, 0, 0, 0, 1, 0, 0, 0, 32'h80));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h80));

        for (int i = 0; i < tbl.size(); i++) begin
            alu_valid = tbl[i].av; alu_num = tbl[i].an; alu_data = tbl[i].ad;
            lsu_valid = tbl[i].lv; lsu_num = tbl[i].ln; lsu_data = tbl[i].ld;
            mark_valid = tbl[i].mv; mark_num = tbl[i].mn;
            q_num1 = tbl[i].q1; q_num2 = tbl[i].q2;
            pre(ga, gl);
            chk($sformatf("v%0d alu_ready", i), {31'd0, alu_ready}, {31'd0, tbl[i].e_ar});
            chk($sformatf("v%0d lsu_ready", i), {31'd0, lsu_ready}, {31'd0, tbl[i].e_lr});
            chk($sformatf("v%0d q_busy1", i), {31'd0, q_busy1}, {31'd0, tbl[i].e_qb1});
            chk($sformatf("v%0d q_busy2", i), {31'd0, q_busy2}, {31'd0, tbl[i].e_qb2});
            post(ga, gl);
            chk($sformatf("v%0d wr_en", i), {31'd0, wr_en}, {31'd0, tbl[i].e_we});
            chk($sformatf("v%0d wr_num", i), {27'd0, wr_num}, {27'd0, tbl[i].e_wn});
            chk($sformatf("v%0d wr_data", i), wr_data, tbl[i].e_wd);
            chk($sformatf("v%0d busy_vec", i), busy_vec, tbl[i].e_busy);
        end

        // Randomized traffic; a requester keeps its request unchanged until it transfers
        a_fired = 1; l_fired = 1;
        for (int i = 0; i < 400; i++) begin
            if (!alu_valid || a_fired) begin
                alu_valid = ($urandom_range(0, 3) != 0);
                alu_num   = 5'($urandom_range(0, 31));
                alu_data  = $urandom;
            end
            if (!lsu_valid || l_fired) begin
                lsu_valid = ($urandom_range(0, 3) != 0);
                lsu_num   = 5'($urandom_range(0, 31));
                lsu_data  = $urandom;
            end
            mark_valid = ($urandom_range(0, 1) != 0);
            mark_num   = 5'($urandom_range(0, 31));
            q_num1     = 5'($urandom_range(0, 31));
            q_num2     = 5'($urandom_range(0, 31));
            pre(ga, gl);
            post(ga, gl);
            a_fired = ga; l_fired = gl;
        end

        // Reset between an accepted transfer and its follow-on capture
        alu_valid = 0; lsu_valid = 0; mark_valid = 1; mark_num = 5'd3; q_num1 = 5'd3; q_num2 = 5'd9;
        pre(ga, gl);
        post(ga, gl);
        alu_valid = 1; alu_num = 5'd9; alu_data = 32'h99; mark_valid = 1; mark_num = 5'd12;
        pre(ga, gl);
        post(ga, gl);
        alu_num = 5'd11; alu_data = 32'hBB; mark_num = 5'd14;
        rst = 1'b1;
        #1;
        model_reset();
        chk("midrst wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst wr_num", {27'd0, wr_num}, 32'd0);
        chk("midrst wr_data", wr_data, 32'd0);
        chk("midrst busy_vec", busy_vec, 32'd0);
        chk("midrst alu_ready", {31'd0, alu_ready}, 32'd0);
        @(posedge clk);
        #1;
        chk("midrst hold wr_en", {31'd0, wr_en}, 32'd0);
        chk("midrst hold busy_vec", busy_vec, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        alu_valid = 1; alu_num = 5'd12; alu_data = 32'hC12;
        lsu_valid = 1; lsu_num = 5'd13; lsu_data = 32'hC13;
        mark_valid = 0; q_num1 = 5'd12; q_num2 = 5'd13;
        pre(ga, gl);
`ifdef WB_RR_ARB_EN
        chk("post-rst first grant alu", {31'd0, alu_ready}, 32'd1);
`else
        chk("post-rst first grant lsu", {31'd0, lsu_ready}, 32'd1);
`endif
        post(ga, gl);
        alu_valid = 0; lsu_valid = 0;
        pre(ga, gl);
        post(ga, gl);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
